lib_vc_transmitter: RTL and testbench

//   Output-port transmitter feeding a downstream router's per-output virtual-channel (VC) input buffer.

---
 rtl/lib_vc_transmitter_pkg.sv | 17 +
 rtl/lib_credit_counter.sv | 57 +++++
 rtl/lib_vc_transmitter.sv | 111 +++++++++++
 tb/tb_lib_vc_transmitter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lib_vc_transmitter_pkg.sv
// Shared configuration for the VC transmitter: packet type and credit-width helper.
package lib_vc_transmitter_pkg;

    localparam int unsigned PKT_W = 32;

    // Packet carried from the switch to the downstream VC buffer.
    typedef struct packed {
        logic [7:0]  tag;
        logic [23:0] payload;
    } packet_t;

    // Bits needed to hold a credit count in the range 0..depth.
    function automatic int unsigned cred_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/lib_credit_counter.sv
// Per-VC credit counter: starts at DEPTH, decrements on send, increments on credit
// return, saturates at DEPTH. With LIB_VC_TX_CREDIT_CHECK_EN an overflow flag
// reports a return arriving while the count is already full and no send occurs.
module lib_credit_counter
    import lib_vc_transmitter_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CRED_W = cred_w(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dec,
    input  logic              inc,
    output logic [CRED_W-1:0] count
`ifdef LIB_VC_TX_CREDIT_CHECK_EN
    ,
    output logic              overflow
`endif
);

    localparam logic [CRED_W-1:0] FULL = CRED_W'(DEPTH);
    localparam logic [CRED_W-1:0] ONE  = CRED_W'(1);

    logic [CRED_W-1:0] count_q;
    logic [CRED_W-1:0] count_d;
    logic              at_full;
    logic              at_empty;

    assign at_full  = (count_q == FULL);
    assign at_empty = (count_q == '0);

    // Next count: send and return together cancel; never wrap below zero or above DEPTH.
    always_comb begin
        count_d = count_q;
        if (dec && !inc && !at_empty) begin
            count_d = count_q - ONE;
        end else if (inc && !dec && !at_full) begin
            count_d = count_q + ONE;
        end
    end

    // Credit state; downstream buffer is empty after reset so all credits are available.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= FULL;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

`ifdef LIB_VC_TX_CREDIT_CHECK_EN
    assign overflow = inc && !dec && at_full;
`endif

endmodule

// File: rtl/lib_vc_transmitter.sv
// Output-port transmitter feeding a downstream router's per-VC input buffers.
// Holds one packet from the switch and only presents it when the target VC has
// credit. Optional sticky protocol checking is enabled by LIB_VC_TX_CREDIT_CHECK_EN.
module lib_vc_transmitter
    import lib_vc_transmitter_pkg::*;
#(
    parameter int unsigned RADIX = 5,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  packet_t          i_data,
    input  logic [0:RADIX-1] i_data_val,
    output logic             o_en,
    output packet_t          o_data,
    output logic [0:RADIX-1] o_data_val,
    input  logic [0:RADIX-1] i_credit
`ifdef LIB_VC_TX_CREDIT_CHECK_EN
    ,
    output logic             o_error
`endif
);

    localparam int unsigned CRED_W = cred_w(DEPTH);

    logic             hold_val_q;
    packet_t          hold_data_q;
    logic [0:RADIX-1] hold_vc_q;

    logic [0:RADIX-1] vc_fix;
    logic [0:RADIX-1] cred_avail;
    logic [CRED_W-1:0] credit [RADIX];
    logic             send;
    logic             accept;

    // Reduce a possibly multi-hot request to the lowest set VC index.
    always_comb begin
        logic found;
        found  = 1'b0;
        vc_fix = '0;
        for (int i = 0; i < RADIX; i++) begin
            if (i_data_val[i] && !found) begin
                vc_fix[i] = 1'b1;
                found     = 1'b1;
            end
        end
    end

    // The held packet leaves only when its VC has at least one credit.
    assign send       = hold_val_q && ((hold_vc_q & cred_avail) != '0);
    assign o_data_val = send ? hold_vc_q : '0;
    assign o_data     = hold_data_q;

    // Accept while the holding register is empty or draining this cycle.
    assign o_en   = !reset && (!hold_val_q || send);
    assign accept = (i_data_val != '0) && o_en;

    // Single-entry holding register between the switch and the link.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_val_q  <= 1'b0;
            hold_data_q <= '0;
            hold_vc_q   <= '0;
        end else if (accept) begin
            hold_val_q  <= 1'b1;
            hold_data_q <= i_data;
            hold_vc_q   <= vc_fix;
        end else if (send) begin
            hold_val_q  <= 1'b0;
        end
    end

`ifdef LIB_VC_TX_CREDIT_CHECK_EN
    logic [0:RADIX-1] ovf;
    logic             multi_hot;
    logic             error_q;

    assign multi_hot = ($countones(i_data_val) > 1);

    // Sticky error: only reset clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            error_q <= 1'b0;
        end else if ((accept && multi_hot) || (ovf != '0)) begin
            error_q <= 1'b1;
        end
    end

    assign o_error = error_q;
`endif

    for (genvar g = 0; g < RADIX; g++) begin : g_vc
        lib_credit_counter #(
            .DEPTH  (DEPTH),
            .CRED_W (CRED_W)
        ) u_credit (
            .clk      (clk),
            .reset    (reset),
            .dec      (o_data_val[g]),
            .inc      (i_credit[g]),
            .count    (credit[g])
`ifdef LIB_VC_TX_CREDIT_CHECK_EN
            ,
            .overflow (ovf[g])
`endif
        );

        assign cred_avail[g] = (credit[g] != '0);
    end

endmodule

// File: tb/tb_lib_vc_transmitter.sv
// Scoreboard bench for lib_vc_transmitter: the driver pushes accepted packets and
// tracks outstanding (sent but not returned) credits per VC; the monitor pops on
// every DUT output and checks order, VC, credit legality and ready/valid timing.
module tb_lib_vc_transmitter;
    import lib_vc_transmitter_pkg::*;

    localparam int unsigned RADIX = 5;
    localparam int unsigned DEPTH = 4;

    logic             clk = 1'b0;
    logic             reset;
    packet_t          i_data;
    packet_t          o_data;
    logic [0:RADIX-1] i_data_val;
    logic [0:RADIX-1] o_data_val;
    logic [0:RADIX-1] i_credit;
    logic             o_en;
`ifdef LIB_VC_TX_CREDIT_CHECK_EN
    logic             o_error;
`endif

    lib_vc_transmitter #(
        .RADIX (RADIX),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .i_data     (i_data),
        .i_data_val (i_data_val),
        .o_en       (o_en),
        .o_data     (o_data),
        .o_data_val (o_data_val),
        .i_credit   (i_credit)
`ifdef LIB_VC_TX_CREDIT_CHECK_EN
        ,
        .o_error    (o_error)
`endif
    );

    always #5 clk = ~clk;

    // Scoreboard: driver appends, monitor advances rd_idx.
    packet_t exp_data[$];
    int      exp_vc[$];
    int      rd_idx = 0;
    int      sent_cnt [RADIX];
    int      ret_cnt  [RADIX];
    bit      err_exp;
    int      n_checks = 0;
    int      n_fail   = 0;

    function automatic logic [0:RADIX-1] onehot(input int v);
        logic [0:RADIX-1] r;
        r    = '0;
        r[v] = 1'b1;
        return r;
    endfunction

    function automatic int lowest(input logic [0:RADIX-1] v);
        for (int i = 0; i < RADIX; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic int outstanding(input int v);
        return sent_cnt[v] - ret_cnt[v];
    endfunction

    function automatic int pending();
        return exp_vc.size() - rd_idx;
    endfunction

    // Return a credit on each VC with outstanding packets, with probability pct%.
    function automatic logic [0:RADIX-1] ret_some(input int pct);
        logic [0:RADIX-1] r;
        r = '0;
        for (int v = 0; v < RADIX; v++)
            if (outstanding(v) > 0 && int'($urandom_range(99)) < pct) r[v] = 1'b1;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
        end
    endtask

    // One clock of stimulus; called at posedge+1, returns at next posedge+1.
    task automatic step(input logic [0:RADIX-1] val, input logic [0:RADIX-1] cred);
        packet_t d;
        logic    acc;
        d          = packet_t'($urandom);
        i_data     = d;
        i_data_val = val;
        i_credit   = cred;
        #1;
        acc = o_en && (val != '0);
        @(posedge clk);
        if (acc) begin
            exp_data.push_back(d);
            exp_vc.push_back(lowest(val));
            if ($countones(val) > 1) err_exp = 1'b1;
        end
        for (int v = 0; v < RADIX; v++) begin
            if (cred[v]) begin
                if (outstanding(v) == 0) err_exp = 1'b1;
                else ret_cnt[v]++;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        err_exp    = 1'b0;
        i_data_val = onehot(2);
        i_credit   = '0;
        #2;
        check("reset_o_en", o_en, 1'b0);
        check("reset_o_data_val", o_data_val, '0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_o_en_hold", o_en, 1'b0);
        reset      = 1'b0;
        i_data_val = '0;
    endtask

    task automatic drain();
        for (int c = 0; c < 60; c++) begin
            bit busy;
            busy = (pending() != 0);
            for (int v = 0; v < RADIX; v++) if (outstanding(v) != 0) busy = 1'b1;
            if (!busy) break;
            step('0, ret_some(100));
        end
        check("drain_pending", pending(), 0);
    endtask

    // Monitor: compare DUT outputs against the scoreboard on every falling edge.
    always @(negedge clk) begin
        if (reset) begin
            rd_idx = exp_vc.size();
            for (int v = 0; v < RADIX; v++) sent_cnt[v] = ret_cnt[v];
        end else begin : mon
            int               hv;
            bit               exp_send;
            logic [0:RADIX-1] exp_val;
            hv       = 0;
            exp_send = 1'b0;
            if (pending() > 0) begin
                hv       = exp_vc[rd_idx];
                exp_send = (outstanding(hv) < int'(DEPTH));
            end
            exp_val = exp_send ? onehot(hv) : '0;
            check("o_en", o_en, (pending() == 0) || exp_send);
            check("o_data_val", o_data_val, exp_val);
            if (o_data_val != '0) begin
                if (pending() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output at %0t: got o_data_val %b, expected none",
                             $time, o_data_val);
                end else begin
                    check("o_data", o_data, exp_data[rd_idx]);
                    rd_idx++;
                    sent_cnt[hv]++;
                end
            end
`ifdef LIB_VC_TX_CREDIT_CHECK_EN
            check("o_error", o_error, err_exp);
`endif
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog at %0t: got timeout, expected completion", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        i_data     = '0;
        i_data_val = '0;
        i_credit   = '0;
        err_exp    = 1'b0;
        for (int v = 0; v < RADIX; v++) ret_cnt[v] = 0;
        @(posedge clk);
        #1;

        // 1: reset behaviour
        do_reset();

        // 2: exhaust VC2, fifth stalls until a credit returns
        repeat (5) step(onehot(2), '0);
        repeat (3) step('0, '0);
        check("vc2_stall_pending", pending(), 1);
        step('0, onehot(2));
        step('0, '0);
        check("vc2_released", pending(), 0);
        drain();

        // 3: alternating VC0/VC1 at full rate with credits returned
        for (int k = 0; k < 6; k++) step(onehot(k % 2), ret_some(100));
        drain();

        // 4: credit[3]=1, send and return in the same cycle
        repeat (4) step(onehot(3), '0);
        step(onehot(3), onehot(3));
        step('0, '0);
        check("vc3_simul_pending", pending(), 0);
        drain();

        // 5: overflow return on a full VC0, then confirm saturation at DEPTH
        step('0, onehot(0));
        repeat (5) step(onehot(0), '0);
        repeat (2) step('0, '0);
        check("vc0_sat_pending", pending(), 1);
        drain();

        // 6: reset while a packet stalls on VC4
        repeat (5) step(onehot(4), '0);
        repeat (2) step('0, '0);
        do_reset();
        repeat (5) step(onehot(4), '0);
        repeat (2) step('0, '0);
        check("vc4_after_reset_pending", pending(), 1);
        drain();

        // Random traffic with random credit returns and occasional multi-hot requests
        for (int c = 0; c < 600; c++) begin
            logic [0:RADIX-1] val;
            int               r;
            r = int'($urandom_range(99));
            if (r < 3) val = RADIX'($urandom_range(1, (1 << RADIX) - 1));
            else if (r < 65) val = onehot(int'($urandom_range(RADIX - 1)));
            else val = '0;
            step(val, ret_some(40));
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
